masked_sbox_rand_gen: RTL and testbench
=======================================

// Module: masked_sbox_rand_gen
// PURPOSE
//  Fresh-randomness source for the masked AES S-box pipeline. A 64-bit LFSR,
//  advanced RAND_W steps per delivered word, drives the ran[13:0] input of
//  the stage-2 PINI multiplier layer through a valid/ready handshake.
//  No word is ever delivered twice. Reusing a mask would break the PINI
//  argument for the downstream stage.
// PARAMETERS
//  RAND_W          14    bits per delivered word (1..32)
//  WARMUP_CYC      8     discarded words after each seed load (0..255)
//  RESEED_INTERVAL 4096  words delivered before reseed_req rises (>=1)
// PORTS
//  clk          in   1       single clock, rising edge
//  rst_n        in   1       asynchronous, active-low reset
//  seed_valid   in   1       load seed this cycle
//  seed         in   64      LFSR seed
//  rand_ready   in   1       consumer accepts rand_data this cycle
//  rand_valid   out  1       rand_data holds a fresh, unused word
//  rand_data    out  RAND_W  random word -> stage-2 ran input
//  reseed_req   out  1       RESEED_INTERVAL words delivered since last seed
//  busy_warmup  out  1       FSM is in WARMUP
// BEHAVIOUR
//  Reset (async on rst_n=0):
//   - state=IDLE, lfsr=0, rand_valid=0, rand_data=0, reseed_req=0,
//     busy_warmup=0, word counter=0, warmup counter=0.
//  LFSR step on s[63:0]:
//   - output bit o = s[63].
//   - f = s[63]^s[62]^s[60]^s[59].
//   - s <= {s[62:0], f}.
//  One "advance":
//   - RAND_W consecutive steps in a single cycle.
//   - Bit i of the produced word is the o of step i (bit 0 comes first).
//  Zero-seed guard: seed==0 is loaded as 64'h1. The LFSR never holds all-zero
//   after a load.
//  FSM:
//   - IDLE: rand_valid=0. On seed_valid: load seed, go to WARMUP, or directly
//     to LOAD if WARMUP_CYC=0.
//   - WARMUP: busy_warmup=1, rand_valid=0. One advance per cycle, output
//     discarded. After WARMUP_CYC advances, go to LOAD.
//   - LOAD: one advance. The word goes into rand_data, rand_valid=1 next
//     cycle. Go to RUN.
//   - RUN: the handshake fires when rand_valid & rand_ready.
//      - On a fire: same-cycle advance, new word registered,
//        rand_valid stays 1. Throughput is 1 word/cycle.
//      - Without a fire: rand_data and rand_valid are held stable.
//  seed_valid in any non-IDLE state:
//   - Reload the LFSR and go to WARMUP/LOAD as from IDLE.
//   - rand_valid=0 from the next cycle; the pending word is dropped, never
//     delivered.
//   - Counter cleared, reseed_req=0.
//   - If seed_valid coincides with a handshake fire, the fire completes
//     (that word counts as consumed) and the seed takes priority for the
//     next state.
//  Word counter:
//   - +1 per fire, saturating at RESEED_INTERVAL.
//   - reseed_req=1 while counter==RESEED_INTERVAL.
//   - Delivery continues while reseed_req=1. Only seed_valid clears it.
//  Latency: seed_valid at cycle 0 gives first rand_valid=1 at cycle
//   WARMUP_CYC+2.
//  Reset asserted mid-operation: all outputs return to reset values at once.
//   No word is valid until a new seed is loaded.
// TESTING
//  T1 reset: rst_n=0 mid-RUN -> rand_valid=0 and reseed_req=0 at once;
//     stays IDLE, no valid, until seed_valid.
//  T2 known vector:
//     - Setup: WARMUP_CYC=0, RAND_W=14, seed=64'h8000_0000_0000_0000.
//     - First word = 14'h0001, rand_valid at cycle 2.
//  T3 backpressure: rand_ready=0 for 5 cycles in RUN -> rand_data constant,
//     rand_valid=1; then ready=1 -> one new word per cycle, no repeats.
//  T4 zero seed: seed=0 -> output stream identical to seed=64'h1.
//  T5 reseed:
//     - Setup: RESEED_INTERVAL=4; ready held 1 for 4 words.
//     - reseed_req rises after the 4th fire and stays high.
//     - seed_valid then clears it; rand_valid=0 during warmup.
//  T6 seed during fire: seed_valid and a fire in the same cycle -> the fired
//     word is consumed, the next word comes from the new seed, and the word
//     pending behind the fire is never presented.

Source files
------------

// File: rtl/masked_sbox_rand_gen.sv
// Fresh-randomness source for the masked AES S-box stage-2 multipliers.
// A 64-bit LFSR advances RAND_W steps per word and feeds a valid/ready output port.
module masked_sbox_rand_gen #(
  parameter int RAND_W          = 14,
  parameter int WARMUP_CYC      = 8,
  parameter int RESEED_INTERVAL = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_valid,
  input  logic [63:0]       seed,
  input  logic              rand_ready,
  output logic              rand_valid,
  output logic [RAND_W-1:0] rand_data,
  output logic              reseed_req,
  output logic              busy_warmup
);

  // Handshake: a word transfers on a rising edge where rand_valid & rand_ready.
  // While rand_valid is high and no transfer happens, rand_data is held stable.
  // A presented word is either transferred once or dropped by a reseed.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    LOAD   = 2'd2,
    RUN    = 2'd3
  } state_t;

  localparam int CNT_W = $clog2(RESEED_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_INTERVAL);
  localparam logic [7:0] WARM_LAST = (WARMUP_CYC == 0) ? 8'd0 : 8'(WARMUP_CYC - 1);
  localparam state_t SEED_DEST = (WARMUP_CYC == 0) ? LOAD : WARMUP;

  state_t            state;
  state_t            state_nxt;
  logic [63:0]       lfsr;
  logic [63:0]       adv_state;
  logic [RAND_W-1:0] adv_word;
  logic [CNT_W-1:0]  word_cnt;
  logic [7:0]        warm_cnt;
  logic              fire;
  logic              adv_en;
  logic              word_en;

  // RAND_W chained LFSR steps; bit i of the word is the output of step i.
  always_comb begin
    logic [63:0] s;
    s        = lfsr;
    adv_word = '0;
    for (int i = 0; i < RAND_W; i++) begin
      adv_word[i] = s[63];
      s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    end
    adv_state = s;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a seed load overrides every state.
  always_comb begin
    state_nxt = state;
    if (seed_valid) begin
      state_nxt = SEED_DEST;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        WARMUP:  if (warm_cnt == WARM_LAST) state_nxt = LOAD;
        LOAD:    state_nxt = RUN;
        RUN:     state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output / control decode
  always_comb begin
    busy_warmup = (state == WARMUP);
    fire        = (state == RUN) && rand_valid && rand_ready;
    adv_en      = 1'b0;
    word_en     = 1'b0;
    if (!seed_valid) begin
      case (state)
        WARMUP: adv_en = 1'b1;
        LOAD: begin
          adv_en  = 1'b1;
          word_en = 1'b1;
        end
        RUN: begin
          adv_en  = fire;
          word_en = fire;
        end
        default: begin
          adv_en  = 1'b0;
          word_en = 1'b0;
        end
      endcase
    end
  end

  // Datapath: LFSR, output word, counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= '0;
      rand_data  <= '0;
      rand_valid <= 1'b0;
      word_cnt   <= '0;
      warm_cnt   <= '0;
    end else if (seed_valid) begin
      // An all-zero LFSR would lock up; substitute the smallest non-zero seed.
      lfsr       <= (seed == 64'd0) ? 64'd1 : seed;
      rand_valid <= 1'b0;
      word_cnt   <= '0;
      warm_cnt   <= '0;
    end else begin
      if (adv_en) begin
        lfsr <= adv_state;
      end
      if (word_en) begin
        rand_data  <= adv_word;
        rand_valid <= 1'b1;
      end
      if (state == WARMUP) begin
        warm_cnt <= warm_cnt + 8'd1;
      end
      if (fire && (word_cnt != CNT_MAX)) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  assign reseed_req = (word_cnt == CNT_MAX);

  // A stalled word must not change under the consumer.
  hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rand_valid && !rand_ready && !seed_valid) |=> (rand_valid && $stable(rand_data)));

  warmup_no_valid: assert property (@(posedge clk) disable iff (!rst_n)
    busy_warmup |-> !rand_valid);

endmodule

// File: tb/tb_masked_sbox_rand_gen.sv
// Bench for masked_sbox_rand_gen: two instances (no warmup / 8-word warmup)
// checked against a bit-stream reference model of the LFSR sequence.
module tb_masked_sbox_rand_gen;

  localparam int WARM_A = 0;
  localparam int INT_A  = 4;
  localparam int WARM_B = 8;
  localparam int INT_B  = 7;
  localparam int FILL_N = 200;

  logic        clk;
  logic        rst_n;
  logic        seed_valid;
  logic [63:0] seed;
  logic        rand_ready;
  logic        a_valid, a_reseed, a_busy;
  logic [13:0] a_data;
  logic        b_valid, b_reseed, b_busy;
  logic [13:0] b_data;

  int checks = 0;
  int errors = 0;

  masked_sbox_rand_gen #(.RAND_W(14), .WARMUP_CYC(WARM_A), .RESEED_INTERVAL(INT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed), .rand_ready(rand_ready),
    .rand_valid(a_valid), .rand_data(a_data), .reseed_req(a_reseed), .busy_warmup(a_busy)
  );

  masked_sbox_rand_gen #(.RAND_W(14), .WARMUP_CYC(WARM_B), .RESEED_INTERVAL(INT_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed(seed), .rand_ready(rand_ready),
    .rand_valid(b_valid), .rand_data(b_data), .reseed_req(b_reseed), .busy_warmup(b_busy)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: output stream o[n+64] = o[n]^o[n+1]^o[n+3]^o[n+4],
  // with o[0..63] = seed[63..0]. Words are consecutive 14-bit chunks, LSB first.
  logic [13:0] exp_q_a[$];
  logic [13:0] exp_q_b[$];
  logic [13:0] ref_q[$];

  task automatic fill(input logic [63:0] seed_v, input int discard, input int n, input int sel);
    bit          bq[$];
    logic [63:0] s;
    logic [13:0] w;
    s = (seed_v == 64'd0) ? 64'd1 : seed_v;
    for (int i = 63; i >= 0; i--) bq.push_back(s[i]);
    for (int k = 0; k < discard + n; k++) begin
      w = '0;
      for (int j = 0; j < 14; j++) begin
        w[j] = bq[0];
        bq.push_back(bq[0] ^ bq[1] ^ bq[3] ^ bq[4]);
        void'(bq.pop_front());
      end
      if (k >= discard) begin
        case (sel)
          0:       exp_q_a.push_back(w);
          1:       exp_q_b.push_back(w);
          default: ref_q.push_back(w);
        endcase
      end
    end
  endtask

  // Per-instance timing model: cycles until the first word, fires since seed.
  logic ma_valid, mb_valid;
  int   ma_cd, mb_cd, ma_fires, mb_fires;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma_valid = 1'b0; ma_cd = 0; ma_fires = 0; exp_q_a.delete();
    end else if (seed_valid) begin
      exp_q_a.delete(); fill(seed, WARM_A, FILL_N, 0);
      ma_valid = 1'b0; ma_cd = WARM_A + 1; ma_fires = 0;
    end else if (ma_valid && rand_ready) begin
      void'(exp_q_a.pop_front());
      if (ma_fires < INT_A) ma_fires++;
    end else if (ma_cd > 0) begin
      ma_cd--;
      if (ma_cd == 0) ma_valid = 1'b1;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mb_valid = 1'b0; mb_cd = 0; mb_fires = 0; exp_q_b.delete();
    end else if (seed_valid) begin
      exp_q_b.delete(); fill(seed, WARM_B, FILL_N, 1);
      mb_valid = 1'b0; mb_cd = WARM_B + 1; mb_fires = 0;
    end else if (mb_valid && rand_ready) begin
      void'(exp_q_b.pop_front());
      if (mb_fires < INT_B) mb_fires++;
    end else if (mb_cd > 0) begin
      mb_cd--;
      if (mb_cd == 0) mb_valid = 1'b1;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_seed(input logic [63:0] s);
    seed = s;
    seed_valid = 1'b1;
    step();
    seed_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; seed_valid = 1'b0; seed = '0; rand_ready = 1'b0;
    repeat (3) step();
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_a_valid got %0b exp 0", a_valid); end
    checks++; if (a_data !== 14'h0) begin errors++; $display("FAIL reset_a_data got %0h exp 0", a_data); end
    checks++; if (a_reseed !== 1'b0) begin errors++; $display("FAIL reset_a_reseed got %0b exp 0", a_reseed); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %0b exp 0", b_busy); end
    rst_n = 1'b1;
    rand_ready = 1'b1;
    repeat (4) step();
    checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_valid got a=%0b b=%0b exp 0", a_valid, b_valid);
    end
  endtask

  task automatic test_known_vector();
    rand_ready = 1'b0;
    load_seed(64'h8000_0000_0000_0000);
    for (int c = 1; c <= 12; c++) begin
      checks++; if (a_valid !== (c >= 2)) begin errors++; $display("FAIL kv_a_valid c=%0d got %0b exp %0b", c, a_valid, c >= 2); end
      checks++; if (b_busy !== (c >= 1 && c <= 8)) begin errors++; $display("FAIL kv_b_busy c=%0d got %0b", c, b_busy); end
      checks++; if (b_valid !== (c >= 10)) begin errors++; $display("FAIL kv_b_valid c=%0d got %0b exp %0b", c, b_valid, c >= 10); end
      if (c >= 2) begin
        checks++; if (a_data !== 14'h0001) begin errors++; $display("FAIL kv_a_data got %0h exp 0001", a_data); end
      end
      if (c >= 10) begin
        checks++; if (b_data !== exp_q_b[0]) begin errors++; $display("FAIL kv_b_data got %0h exp %0h", b_data, exp_q_b[0]); end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [13:0] hold;
    hold = exp_q_a[0];
    rand_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++; if (a_valid !== 1'b1 || a_data !== hold) begin
        errors++; $display("FAIL bp_hold_a got v=%0b d=%0h exp v=1 d=%0h", a_valid, a_data, hold);
      end
      checks++; if (b_valid !== 1'b1 || b_data !== exp_q_b[0]) begin
        errors++; $display("FAIL bp_hold_b got v=%0b d=%0h exp d=%0h", b_valid, b_data, exp_q_b[0]);
      end
      step();
    end
    rand_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checks++; if (a_valid !== 1'b1 || a_data !== exp_q_a[0]) begin
        errors++; $display("FAIL bp_stream_a c=%0d got v=%0b d=%0h exp d=%0h", c, a_valid, a_data, exp_q_a[0]);
      end
      checks++; if (a_reseed !== (ma_fires >= INT_A)) begin
        errors++; $display("FAIL bp_reseed_a c=%0d got %0b exp %0b", c, a_reseed, ma_fires >= INT_A);
      end
      checks++; if (b_data !== exp_q_b[0]) begin
        errors++; $display("FAIL bp_stream_b c=%0d got %0h exp %0h", c, b_data, exp_q_b[0]);
      end
      step();
    end
  endtask

  task automatic test_zero_seed();
    rand_ready = 1'b1;
    ref_q.delete();
    fill(64'h1, 0, 12, 2);
    load_seed(64'h0);
    for (int c = 1; c <= 10; c++) begin
      checks++; if (a_valid !== (c >= 2)) begin errors++; $display("FAIL zs_valid c=%0d got %0b", c, a_valid); end
      if (c >= 2) begin
        checks++; if (a_data !== ref_q[c-2]) begin errors++; $display("FAIL zs_data c=%0d got %0h exp %0h", c, a_data, ref_q[c-2]); end
      end
      step();
    end
  endtask

  task automatic test_reseed();
    rand_ready = 1'b1;
    load_seed({$urandom, $urandom});
    for (int c = 1; c <= 20; c++) begin
      checks++; if (a_reseed !== (c >= 6)) begin errors++; $display("FAIL rs_a_req c=%0d got %0b exp %0b", c, a_reseed, c >= 6); end
      checks++; if (a_valid !== (c >= 2)) begin errors++; $display("FAIL rs_a_valid c=%0d got %0b", c, a_valid); end
      checks++; if (b_reseed !== (c >= 17)) begin errors++; $display("FAIL rs_b_req c=%0d got %0b exp %0b", c, b_reseed, c >= 17); end
      checks++; if (b_valid !== (c >= 10)) begin errors++; $display("FAIL rs_b_valid c=%0d got %0b", c, b_valid); end
      step();
    end
    load_seed({$urandom, $urandom});
    for (int c = 1; c <= 9; c++) begin
      checks++; if (a_reseed !== (c >= 6)) begin errors++; $display("FAIL rs2_a_req c=%0d got %0b exp %0b", c, a_reseed, c >= 6); end
      checks++; if (b_reseed !== 1'b0 || b_valid !== 1'b0) begin
        errors++; $display("FAIL rs2_b c=%0d got req=%0b v=%0b exp 0", c, b_reseed, b_valid);
      end
      checks++; if (b_busy !== (c <= 8)) begin errors++; $display("FAIL rs2_b_busy c=%0d got %0b", c, b_busy); end
      if (c == 1) begin
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL rs2_a_valid got %0b exp 0", a_valid); end
      end
      step();
    end
  endtask

  task automatic test_seed_during_fire();
    logic [63:0] ns;
    logic [13:0] stale;
    checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL sdf_pre_valid got %0b exp 1", a_valid); end
    stale = exp_q_a[1];
    ns = {$urandom, $urandom};
    ref_q.delete();
    fill(ns, 0, 1, 2);
    rand_ready = 1'b1;
    load_seed(ns);
    checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL sdf_drop got %0b exp 0", a_valid); end
    step();
    checks++; if (a_valid !== 1'b1 || a_data !== ref_q[0]) begin
      errors++; $display("FAIL sdf_new_word got v=%0b d=%0h exp d=%0h", a_valid, a_data, ref_q[0]);
    end
    if (stale != ref_q[0]) begin
      checks++; if (a_data === stale) begin errors++; $display("FAIL sdf_stale got %0h exp not %0h", a_data, stale); end
    end
  endtask

  task automatic test_reset_mid_run();
    rand_ready = 1'b1;
    repeat (4) step();
    checks++; if (a_reseed !== 1'b1) begin errors++; $display("FAIL rmr_pre_req got %0b exp 1", a_reseed); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_valid !== 1'b0 || a_reseed !== 1'b0 || a_data !== 14'h0) begin
      errors++; $display("FAIL rmr_async got v=%0b req=%0b d=%0h exp 0", a_valid, a_reseed, a_data);
    end
    checks++; if (b_valid !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL rmr_async_b got v=%0b busy=%0b exp 0", b_valid, b_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
        errors++; $display("FAIL rmr_idle c=%0d got a=%0b b=%0b exp 0", c, a_valid, b_valid);
      end
    end
  endtask

  task automatic test_random_traffic();
    load_seed({$urandom, $urandom});
    for (int c = 0; c < 300; c++) begin
      rand_ready = ($urandom_range(0, 3) != 0);
      seed_valid = ($urandom_range(0, 59) == 0);
      seed = ($urandom_range(0, 5) == 0) ? 64'd0 : {$urandom, $urandom};
      checks++; if (a_valid !== ma_valid || (ma_valid && a_data !== exp_q_a[0])) begin
        errors++; $display("FAIL rnd_a c=%0d got v=%0b d=%0h exp v=%0b d=%0h", c, a_valid, a_data, ma_valid, exp_q_a[0]);
      end
      checks++; if (b_valid !== mb_valid || (mb_valid && b_data !== exp_q_b[0])) begin
        errors++; $display("FAIL rnd_b c=%0d got v=%0b d=%0h exp v=%0b d=%0h", c, b_valid, b_data, mb_valid, exp_q_b[0]);
      end
      checks++; if (a_reseed !== (ma_fires == INT_A) || b_reseed !== (mb_fires == INT_B)) begin
        errors++; $display("FAIL rnd_req c=%0d got a=%0b b=%0b exp a=%0b b=%0b", c, a_reseed, b_reseed, ma_fires == INT_A, mb_fires == INT_B);
      end
      checks++; if (a_busy !== (ma_cd > 1) || b_busy !== (mb_cd > 1)) begin
        errors++; $display("FAIL rnd_busy c=%0d got a=%0b b=%0b exp a=%0b b=%0b", c, a_busy, b_busy, ma_cd > 1, mb_cd > 1);
      end
      step();
    end
    seed_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_backpressure();
    test_zero_seed();
    test_reseed();
    test_seed_during_fire();
    test_reset_mid_run();
    test_random_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
